// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with a one-entry buffer per channel.
// The target channel comes from S (addressed) or from a round-robin pointer.
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   D,
  input  logic               D_VALID,
  output logic               D_READY,
  input  logic [SEL_W-1:0]   S,
  input  logic               MODE,
  output logic [N*WIDTH-1:0] Y,
  output logic [N-1:0]       Y_VALID,
  input  logic [N-1:0]       Y_READY,
  output logic [7:0]         DROP_CNT
);

  logic [N*WIDTH-1:0] y_q;
  logic [N-1:0]       y_valid_q;
  logic [SEL_W-1:0]   rr_q;
  logic [7:0]         drop_q;

  logic [SEL_W-1:0]   tgt;
  logic               tgt_ok;
  logic               tgt_free;
  logic               accept;
  logic [N-1:0]       wr_sel;

  always_comb begin
    tgt      = MODE ? rr_q : S;
    tgt_ok   = MODE || ({1'b0, S} < (SEL_W+1)'(N));
    tgt_free = 1'b0;
    wr_sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (tgt == SEL_W'(k)) begin
        tgt_free = !y_valid_q[k] || Y_READY[k];
      end
    end
    // Out-of-range selects are always accepted so they can be discarded.
    D_READY = tgt_ok ? tgt_free : 1'b1;
    accept  = D_VALID && D_READY;
    for (int unsigned k = 0; k < N; k++) begin
      wr_sel[k] = accept && tgt_ok && (tgt == SEL_W'(k));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q       <= '0;
      y_valid_q <= '0;
      rr_q      <= '0;
      drop_q    <= '0;
    end else begin
      // A write to a channel takes precedence over its drain in the same cycle.
      for (int unsigned k = 0; k < N; k++) begin
        if (wr_sel[k]) begin
          y_q[k*WIDTH +: WIDTH] <= D;
          y_valid_q[k]          <= 1'b1;
        end else if (y_valid_q[k] && Y_READY[k]) begin
          y_q[k*WIDTH +: WIDTH] <= '0;
          y_valid_q[k]          <= 1'b0;
        end
      end
      if (accept && MODE) begin
        rr_q <= (rr_q == SEL_W'(N-1)) ? '0 : rr_q + SEL_W'(1);
      end
      if (accept && !tgt_ok && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign Y        = y_q;
  assign Y_VALID  = y_valid_q;
  assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a 4-channel build driven from a vector
// table plus hand sequences, and a 3-channel build for invalid selects.
module tb_demux_stream;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 4-channel instance
  logic        rst4, mode4, dv4, rdy4;
  logic [7:0]  d4, drop4;
  logic [1:0]  s4;
  logic [31:0] y4;
  logic [3:0]  yv4, yr4;

  // 3-channel instance
  logic        rst3, mode3, dv3, rdy3;
  logic [7:0]  d3, drop3;
  logic [1:0]  s3;
  logic [23:0] y3;
  logic [2:0]  yv3, yr3;

  demux_stream #(.WIDTH(8), .N(4), .SEL_W(2)) u_dut4 (
    .CLK(CLK), .RST(rst4), .D(d4), .D_VALID(dv4), .D_READY(rdy4), .S(s4),
    .MODE(mode4), .Y(y4), .Y_VALID(yv4), .Y_READY(yr4), .DROP_CNT(drop4)
  );

  demux_stream #(.WIDTH(8), .N(3), .SEL_W(2)) u_dut3 (
    .CLK(CLK), .RST(rst3), .D(d3), .D_VALID(dv3), .D_READY(rdy3), .S(s3),
    .MODE(mode3), .Y(y3), .Y_VALID(yv3), .Y_READY(yr3), .DROP_CNT(drop3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  s;
    logic [7:0]  d;
    logic        dv;
    logic [3:0]  yr;
    logic        rdy;  // D_READY before the edge
    logic [3:0]  yv;   // Y_VALID after the edge
    logic [31:0] y;    // Y after the edge
  } vec_t;

  vec_t vec[21];

  initial begin
    // reset idle: D_READY for S=0..3
    vec[0]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000};
    vec[1]  = '{1'b0, 2'd1, 8'h00, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000};
    vec[2]  = '{1'b0, 2'd2, 8'h00, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000};
    vec[3]  = '{1'b0, 2'd3, 8'h00, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000};
    // addressed routing, then backpressure and pass-through on channel 1
    vec[4]  = '{1'b0, 2'd2, 8'hA5, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000};
    vec[5]  = '{1'b0, 2'd1, 8'h77, 1'b1, 4'b0000, 1'b1, 4'b0110, 32'h00A5_7700};
    vec[6]  = '{1'b0, 2'd1, 8'h3C, 1'b1, 4'b0000, 1'b0, 4'b0110, 32'h00A5_7700};
    vec[7]  = '{1'b0, 2'd1, 8'h3C, 1'b1, 4'b0010, 1'b1, 4'b0110, 32'h00A5_3C00};
    vec[8]  = '{1'b0, 2'd1, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000};
    // round-robin, all consumers ready
    vec[9]  = '{1'b1, 2'd0, 8'h01, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h0000_0001};
    vec[10] = '{1'b1, 2'd0, 8'h02, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0000_0200};
    vec[11] = '{1'b1, 2'd0, 8'h03, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h0003_0000};
    vec[12] = '{1'b1, 2'd0, 8'h04, 1'b1, 4'b1111, 1'b1, 4'b1000, 32'h0400_0000};
    vec[13] = '{1'b1, 2'd0, 8'h05, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h0000_0005};
    // RR is now 1: next word lands on channel 1
    vec[14] = '{1'b1, 2'd0, 8'h06, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h0000_0605};
    // fill channel 2 in addressed mode, RR stays 2, then stall on it
    vec[15] = '{1'b0, 2'd2, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b0111, 32'h0011_0605};
    vec[16] = '{1'b1, 2'd0, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b0111, 32'h0011_0605};
    vec[17] = '{1'b1, 2'd0, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b0111, 32'h0011_0605};
    vec[18] = '{1'b1, 2'd0, 8'h22, 1'b1, 4'b0100, 1'b1, 4'b0111, 32'h0022_0605};
    vec[19] = '{1'b1, 2'd0, 8'h33, 1'b1, 4'b0000, 1'b1, 4'b1111, 32'h3322_0605};
    vec[20] = '{1'b1, 2'd0, 8'h44, 1'b1, 4'b0000, 1'b0, 4'b1111, 32'h3322_0605};

    rst4 = 1'b1; mode4 = 1'b0; dv4 = 1'b0; d4 = '0; s4 = '0; yr4 = '0;
    rst3 = 1'b1; mode3 = 1'b0; dv3 = 1'b0; d3 = '0; s3 = '0; yr3 = '0;
    @(posedge CLK); #1;
    rst4 = 1'b0; rst3 = 1'b0;
    chk("rst_y", y4, 32'h0);
    chk("rst_yvalid", {28'h0, yv4}, 32'h0);
    chk("rst_drop", {24'h0, drop4}, 32'h0);

    for (int i = 0; i < 21; i++) begin
      mode4 = vec[i].mode; s4 = vec[i].s; d4 = vec[i].d;
      dv4 = vec[i].dv; yr4 = vec[i].yr;
      @(negedge CLK);
      chk($sformatf("vec%0d_dready", i), {31'h0, rdy4}, {31'h0, vec[i].rdy});
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_yvalid", i), {28'h0, yv4}, {28'h0, vec[i].yv});
      chk($sformatf("vec%0d_y", i), y4, vec[i].y);
      chk($sformatf("vec%0d_drop", i), {24'h0, drop4}, 32'h0);
    end

    // reset with all buffers full wins over a simultaneous valid word
    rst4 = 1'b1; mode4 = 1'b0; s4 = 2'd0; d4 = 8'hFF; dv4 = 1'b1; yr4 = '0;
    @(posedge CLK); #1;
    rst4 = 1'b0;
    chk("midrst4_y", y4, 32'h0);
    chk("midrst4_yvalid", {28'h0, yv4}, 32'h0);
    chk("midrst4_drop", {24'h0, drop4}, 32'h0);
    // RR back at 0
    mode4 = 1'b1; d4 = 8'h55; dv4 = 1'b1;
    @(posedge CLK); #1;
    dv4 = 1'b0;
    chk("midrst4_rr_y", y4, 32'h0000_0055);
    chk("midrst4_rr_yvalid", {28'h0, yv4}, 32'h1);

    // 3-channel build: fill all channels, then 300 out-of-range words
    dv3 = 1'b1; mode3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s3 = 2'(k); d3 = 8'hA1 + 8'(k);
      @(posedge CLK); #1;
    end
    chk("n3_fill_y", {8'h0, y3}, 32'h00A3_A2A1);
    chk("n3_fill_yvalid", {29'h0, yv3}, 32'h7);
    s3 = 2'd3; d3 = 8'hEE;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      chk($sformatf("n3_drop%0d_dready", i), {31'h0, rdy3}, 32'h1);
      @(posedge CLK); #1;
      chk($sformatf("n3_drop%0d_yvalid", i), {29'h0, yv3}, 32'h7);
      if (i == 0)   chk("n3_drop_first", {24'h0, drop3}, 32'd1);
      if (i == 253) chk("n3_drop_254", {24'h0, drop3}, 32'd254);
      if (i == 254) chk("n3_drop_255", {24'h0, drop3}, 32'd255);
    end
    chk("n3_drop_sat", {24'h0, drop3}, 32'd255);
    chk("n3_y_held", {8'h0, y3}, 32'h00A3_A2A1);

    rst3 = 1'b1;
    @(posedge CLK); #1;
    rst3 = 1'b0; dv3 = 1'b0; s3 = 2'd0;
    chk("n3_rst_y", {8'h0, y3}, 32'h0);
    chk("n3_rst_yvalid", {29'h0, yv3}, 32'h0);
    chk("n3_rst_drop", {24'h0, drop3}, 32'h0);
    @(negedge CLK);
    chk("n3_rst_dready", {31'h0, rdy3}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
